// File: rtl/seg7_scan.sv
// seg7_scan: 4-digit multiplexed 7-segment hex display scanner.
// Samples a divided scan clock as data and derives one-cycle scan ticks from it.
// Display data is latched into shadow registers once per frame, on entry to
// digit 0. Each digit change leaves the anodes dark for one cycle.
module seg7_scan #(
  parameter bit AN_ACTIVE_LOW  = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scan_clk,
  input  logic [15:0] value,
  input  logic [3:0]  dp,
  input  logic [3:0]  digit_en,
  input  logic        lz_blank,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp_out,
  output logic        frame_done
);

  localparam logic [3:0] AN_OFF  = AN_ACTIVE_LOW  ? 4'hF  : 4'h0;
  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic       DP_OFF  = SEG_ACTIVE_LOW;

  logic        sync1, sync2, sync3;
  logic        tick;
  logic [1:0]  idx;
  logic [15:0] sh_value;
  logic [3:0]  sh_dp;
  logic [3:0]  sh_en;
  logic        sh_lz;
  logic        lit_pend;
  logic        vis_q;

  logic        frame_load;
  logic [1:0]  idx_next;
  logic [15:0] cur_value;
  logic [3:0]  cur_dp;
  logic [3:0]  cur_en;
  logic        cur_lz;
  logic [3:0]  nibble;
  logic        blanked;
  logic        visible;
  logic [6:0]  pattern;
  logic [3:0]  onehot;

  // Hex digit to active-high gfedcba segment pattern.
  function automatic logic [6:0] hex_decode(input logic [3:0] h);
    case (h)
      4'h0: return 7'h3F;
      4'h1: return 7'h06;
      4'h2: return 7'h5B;
      4'h3: return 7'h4F;
      4'h4: return 7'h66;
      4'h5: return 7'h6D;
      4'h6: return 7'h7D;
      4'h7: return 7'h07;
      4'h8: return 7'h7F;
      4'h9: return 7'h6F;
      4'hA: return 7'h77;
      4'hB: return 7'h7C;
      4'hC: return 7'h39;
      4'hD: return 7'h5E;
      4'hE: return 7'h79;
      default: return 7'h71;
    endcase
  endfunction

  // Three-stage sampler of the asynchronous scan clock.
  // NOTE: all sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= scan_clk;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign tick       = sync2 & ~sync3;
  assign frame_load = tick && (idx == 2'd3);
  assign idx_next   = idx + 2'd1;
  assign onehot     = 4'b0001 << idx;

  // Select the data for the digit being entered, bypassing the shadows on frame entry.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    cur_value = sh_value;
    cur_dp    = sh_dp;
    cur_en    = sh_en;
    cur_lz    = sh_lz;
    if (frame_load) begin
      cur_value = value;
      cur_dp    = dp;
      cur_en    = digit_en;
      cur_lz    = lz_blank;
    end
    nibble  = cur_value[{idx_next, 2'b00} +: 4];
    blanked = 1'b0;
    case (idx_next)
      2'd1:    blanked = cur_lz && (cur_value[15:4]  == 12'h000);
      2'd2:    blanked = cur_lz && (cur_value[15:8]  == 8'h00);
      2'd3:    blanked = cur_lz && (cur_value[15:12] == 4'h0);
      default: blanked = 1'b0;
    endcase
    visible = cur_en[idx_next] && !blanked;
    pattern = visible ? hex_decode(nibble) : 7'h00;
  end

  // Frame shadow registers, index advance and output drive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx        <= 2'd3;
      sh_value   <= 16'h0000;
      sh_dp      <= 4'h0;
      sh_en      <= 4'h0;
      sh_lz      <= 1'b0;
      lit_pend   <= 1'b0;
      vis_q      <= 1'b0;
      an         <= AN_OFF;
      seg        <= SEG_OFF;
      dp_out     <= DP_OFF;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_load;
      lit_pend   <= 1'b0;
      if (frame_load) begin
        sh_value <= value;
        sh_dp    <= dp;
        sh_en    <= digit_en;
        sh_lz    <= lz_blank;
      end
      if (tick) begin
        // Dark cycle: anodes off while the segments settle on the new pattern.
        idx      <= idx_next;
        an       <= AN_OFF;
        seg      <= SEG_ACTIVE_LOW ? ~pattern : pattern;
        dp_out   <= SEG_ACTIVE_LOW ? ~(visible & cur_dp[idx_next])
                                   : (visible & cur_dp[idx_next]);
        vis_q    <= visible;
        lit_pend <= 1'b1;
      end else if (lit_pend) begin
        an <= vis_q ? (AN_ACTIVE_LOW ? ~onehot : onehot) : AN_OFF;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// Directed testbench for seg7_scan with default (active-low) polarities.
module tb_seg7_scan;

  logic        clk;
  logic        rst;
  logic        scan_clk;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [3:0]  digit_en;
  logic        lz_blank;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp_out;
  logic        frame_done;

  int total;
  int bad;

  logic gap_chk;
  logic dp_chk;

  seg7_scan dut (
    .clk        (clk),
    .rst        (rst),
    .scan_clk   (scan_clk),
    .value      (value),
    .dp         (dp),
    .digit_en   (digit_en),
    .lz_blank   (lz_blank),
    .an         (an),
    .seg        (seg),
    .dp_out     (dp_out),
    .frame_done (frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Scan clock: 4 clk high, 4 clk low.
  initial begin
    scan_clk = 1'b0;
    forever begin
      repeat (4) @(negedge clk);
      scan_clk = ~scan_clk;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Scan monitor: anode exclusivity, single dark cycle per change, dp placement.
  logic [3:0] prev_an;
  logic       have_lit;
  int         dark_len;
  initial begin
    prev_an  = 4'hF;
    have_lit = 1'b0;
    dark_len = 0;
    forever begin
      @(negedge clk);
      if (rst || !gap_chk) begin
        have_lit = 1'b0;
        dark_len = 0;
      end
      if (!rst) begin
        total++;
        if ($countones(~an) > 1) begin
          bad++;
          $display("FAIL mon_onehot: an=%b required at most one low bit", an);
        end
        if (prev_an != 4'hF && an != 4'hF && an != prev_an) begin
          total++;
          bad++;
          $display("FAIL mon_no_gap: an %b -> %b required one dark cycle", prev_an, an);
        end
        if (gap_chk && have_lit && prev_an == 4'hF && an != 4'hF) begin
          total++;
          if (dark_len != 1) begin
            bad++;
            $display("FAIL mon_gap_len: dark=%0d required 1", dark_len);
          end
        end
        if (dp_chk && an != 4'hF) begin
          total++;
          if (dp_out !== (an == 4'b1011 ? 1'b0 : 1'b1)) begin
            bad++;
            $display("FAIL mon_dp: an=%b dp_out=%b required %b", an, dp_out,
                     (an == 4'b1011) ? 1'b0 : 1'b1);
          end
        end
        if (an == 4'hF) dark_len++;
        else begin
          dark_len = 0;
          if (gap_chk) have_lit = 1'b1;
        end
      end
      prev_an = an;
    end
  end

  // Wait for a frame_done pulse; returns at the negedge where it is seen.
  task automatic wait_frame(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (frame_done) ok = 1'b1;
    end
  endtask

  // Wait for the start of the next freshly lit digit slot.
  task automatic get_slot(output logic [3:0] a, output logic [6:0] s,
                          output logic fd, output logic ok);
    logic dark;
    dark = (an == 4'hF);
    fd = 1'b0;
    ok = 1'b0;
    a  = 4'hF;
    s  = 7'h7F;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (frame_done) fd = 1'b1;
      if (an == 4'hF) dark = 1'b1;
      else if (dark) begin
        a  = an;
        s  = seg;
        ok = 1'b1;
      end
    end
  endtask

  task automatic test_reset;
    logic ok;
    @(negedge clk);
    rst      = 1'b1;
    value    = 16'h1234;
    digit_en = 4'hF;
    repeat (3) @(negedge clk);
    total++;
    if (an !== 4'hF || seg !== 7'h7F || dp_out !== 1'b1 || frame_done !== 1'b0) begin
      bad++;
      $display("FAIL reset_vals: an=%b seg=%h dp=%b fd=%b required 1111 7f 1 0",
               an, seg, dp_out, frame_done);
    end
    rst = 1'b0;
    ok  = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (frame_done) ok = 1'b1;
      else begin
        total++;
        if (an !== 4'hF) begin
          bad++;
          $display("FAIL reset_dark: an=%b before frame_done required 1111", an);
        end
      end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL reset_first_frame: no frame_done required one");
    end
  endtask

  task automatic test_basic;
    logic [3:0] exp_an  [4];
    logic [6:0] exp_seg [4];
    logic [3:0] a;
    logic [6:0] s;
    logic fd, ok;
    exp_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    exp_seg = '{7'h0E, 7'h24, 7'h08, 7'h79};
    value    = 16'h1A2F;
    digit_en = 4'hF;
    lz_blank = 1'b0;
    dp       = 4'b0100;
    wait_frame(ok);
    gap_chk = 1'b1;
    dp_chk  = 1'b1;
    total++;
    if (!ok) begin bad++; $display("FAIL basic_frame: timeout"); end
    for (int f = 0; f < 2; f++) begin
      for (int d = 0; d < 4; d++) begin
        get_slot(a, s, fd, ok);
        total++;
        if (!ok || a !== exp_an[d] || s !== exp_seg[d]) begin
          bad++;
          $display("FAIL basic_slot%0d: an=%b seg=%h required %b %h",
                   d, a, s, exp_an[d], exp_seg[d]);
        end
      end
    end
    dp_chk = 1'b0;
  endtask

  task automatic test_lz_blank;
    logic [3:0] a;
    logic [6:0] s;
    logic fd, ok, seen;
    gap_chk  = 1'b0;
    dp       = 4'h0;
    lz_blank = 1'b1;
    digit_en = 4'hF;
    // 0x0005: only digit 0 ever lit
    value = 16'h0005;
    wait_frame(ok);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (an != 4'hF) begin
        total++;
        if (an !== 4'b1110 || seg !== 7'h12) begin
          bad++;
          $display("FAIL lz_0005: an=%b seg=%h required 1110 12", an, seg);
        end
        seen = 1'b1;
      end
    end
    total++;
    if (!ok || !seen) begin bad++; $display("FAIL lz_0005_seen: digit 0 never lit"); end
    // 0x0000: digit 0 shows zero
    value = 16'h0000;
    wait_frame(ok);
    get_slot(a, s, fd, ok);
    total++;
    if (!ok || a !== 4'b1110 || s !== 7'h40) begin
      bad++;
      $display("FAIL lz_0000: an=%b seg=%h required 1110 40", a, s);
    end
    get_slot(a, s, fd, ok);
    total++;
    if (!ok || a !== 4'b1110) begin
      bad++;
      $display("FAIL lz_0000_only: an=%b required 1110", a);
    end
    // 0x0300: digits 0..2 shown, digit 3 dark
    value = 16'h0300;
    wait_frame(ok);
    get_slot(a, s, fd, ok);
    total++;
    if (!ok || a !== 4'b1110 || s !== 7'h40) begin
      bad++; $display("FAIL lz_0300_d0: an=%b seg=%h required 1110 40", a, s);
    end
    get_slot(a, s, fd, ok);
    total++;
    if (!ok || a !== 4'b1101 || s !== 7'h40) begin
      bad++; $display("FAIL lz_0300_d1: an=%b seg=%h required 1101 40", a, s);
    end
    get_slot(a, s, fd, ok);
    total++;
    if (!ok || a !== 4'b1011 || s !== 7'h30) begin
      bad++; $display("FAIL lz_0300_d2: an=%b seg=%h required 1011 30", a, s);
    end
    get_slot(a, s, fd, ok);
    total++;
    if (!ok || a !== 4'b1110) begin
      bad++; $display("FAIL lz_0300_d3dark: an=%b required 1110", a);
    end
  endtask

  task automatic test_tearing;
    logic [3:0] a;
    logic [6:0] s;
    logic fd, ok;
    lz_blank = 1'b0;
    digit_en = 4'hF;
    value    = 16'h1111;
    wait_frame(ok);
    get_slot(a, s, fd, ok);
    gap_chk = 1'b1;
    total++;
    if (!ok || a !== 4'b1110 || s !== 7'h79) begin
      bad++; $display("FAIL tear_d0: an=%b seg=%h required 1110 79", a, s);
    end
    get_slot(a, s, fd, ok);
    total++;
    if (!ok || a !== 4'b1101) begin
      bad++; $display("FAIL tear_d1: an=%b required 1101", a);
    end
    value = 16'h2222;
    get_slot(a, s, fd, ok);
    total++;
    if (!ok || a !== 4'b1011 || s !== 7'h79) begin
      bad++; $display("FAIL tear_d2: an=%b seg=%h required 1011 79", a, s);
    end
    get_slot(a, s, fd, ok);
    total++;
    if (!ok || a !== 4'b0111 || s !== 7'h79 || fd) begin
      bad++; $display("FAIL tear_d3: an=%b seg=%h fd=%b required 0111 79 0", a, s, fd);
    end
    get_slot(a, s, fd, ok);
    total++;
    if (!ok || a !== 4'b1110 || s !== 7'h24 || !fd) begin
      bad++; $display("FAIL tear_new: an=%b seg=%h fd=%b required 1110 24 1", a, s, fd);
    end
  endtask

  task automatic test_mid_reset;
    logic [3:0] a;
    logic [6:0] s;
    logic fd, ok, found;
    value = 16'h1A2F;
    wait_frame(ok);
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      get_slot(a, s, fd, ok);
      if (ok && a == 4'b1011) found = 1'b1;
    end
    total++;
    if (!found) begin bad++; $display("FAIL mrst_find: digit 2 not reached"); end
    rst = 1'b1;
    #1;
    total++;
    if (an !== 4'hF || seg !== 7'h7F) begin
      bad++; $display("FAIL mrst_async: an=%b seg=%h required 1111 7f", an, seg);
    end
    @(negedge clk);
    rst = 1'b0;
    get_slot(a, s, fd, ok);
    total++;
    if (!ok || a !== 4'b1110 || s !== 7'h0E || !fd) begin
      bad++;
      $display("FAIL mrst_resume: an=%b seg=%h fd=%b required 1110 0e 1", a, s, fd);
    end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    gap_chk  = 1'b0;
    dp_chk   = 1'b0;
    rst      = 1'b1;
    value    = 16'h0000;
    dp       = 4'h0;
    digit_en = 4'h0;
    lz_blank = 1'b0;
    test_reset();
    test_basic();
    test_lz_blank();
    test_tearing();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg7_scan.md
# seg7_scan

Scan controller for the 4-digit 7-segment hex display. It consumes the slow divided clock from the clock-divider stage as a sampled strobe, not as a clock. From it, the block generates one-cycle scan ticks, time-multiplexes four hex digits onto shared segment lines, and drives anodes, segments and decimal point. Display data is latched once per frame so a digit pattern never tears mid-scan; optional leading-zero blanking and per-digit enables sit on top.

## Interface
- AN_ACTIVE_LOW, 1: 1 = anode asserted low (common-anode board); 0 = asserted high.
- SEG_ACTIVE_LOW, 1: 1 = segment/dp lit when low; 0 = lit when high.
- clk  in  1  system clock; all logic in this domain.
- rst  in  1  reset, asynchronous, active-high.
- scan_clk  in  1  divided clock from divider stage; treated as asynchronous data.
- value  in  16  hex value; value[3:0] = digit 0 (rightmost).
- dp  in  4  decimal point request per digit; dp[i] for digit i.
- digit_en  in  4  per-digit enable; 0 = digit dark.
- lz_blank  in  1  1 = blank leading zero digits.
- an  out  4  anode drive; an[i] selects digit i.
- seg  out  7  segments, seg[0]=a … seg[6]=g.
- dp_out  out  1  decimal point drive.
- frame_done  out  1  one-cycle pulse when new frame data is latched.

## Operation
- Tick generator: scan_clk → sync1 → sync2 → sync3 flops, all reset 0; tick = sync2 & ~sync3. Every scan_clk high and low phase must last ≥2 clk cycles.
- Digit index idx (2 bits) resets to 3. Each tick does idx ← idx+1, wrapping 3→0, so the first tick after reset starts at digit 0.
- Shadow registers hold value, dp, digit_en and lz_blank. All reset to 0. They load from the inputs on a tick where idx==3, i.e. when entering digit 0. frame_done pulses on that same edge.
- Visibility of digit i: shadow digit_en[i]=1, and it is not lz-blanked.
- lz-blank rule: with shadow lz_blank=1, digit i∈{3,2,1} is blanked when all nibbles i..3 are 0. Digit 0 is never lz-blanked, so 0x0000 shows "0".
- Hex decode, active-high gfedcba: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
- Polarity: the pattern is inverted when SEG_ACTIVE_LOW=1. dp_out carries the shadow dp[idx] with the same polarity rule. an is one-hot of idx, inverted when AN_ACTIVE_LOW=1.
- Invisible digit: an stays all-inactive for that slot. seg and dp_out are driven off.
- Ghost suppression: every digit change inserts exactly one clk cycle with all anodes inactive. Two anodes are never active in the same cycle.
- Reset values, applied asynchronously:
  - an = all inactive (4'b1111 when active low)
  - seg = all off (7'h7F when active low)
  - dp_out = off
  - frame_done = 0

## Timing
- Edge E0: first clk edge sampling scan_clk=1. tick is high during the cycle after E1. Edge E2 is the tick edge.
- At E2:
  - idx advances.
  - an goes all-inactive.
  - seg and dp_out load the pattern for the new idx.
  - On frame entry, seg and dp_out use the newly latched shadow data, bypassing the shadow registers.
- At E3: an asserts the new digit if it is visible.
- Latency from scan_clk rise to new digit lit: 3–4 clk cycles.
- Input changes have no visible effect until the next frame_done.
- Reset mid-frame: outputs go to reset values immediately. After release, the first tick shows digit 0 with freshly latched data.
- Each digit is lit for one scan_clk period minus 1 clk cycle. One frame is 4 scan_clk periods.

## Test plan
- Reset with value=0x1234 and digit_en=F applied: an=1111, seg=7F, dp_out=1, frame_done=0. All digits stay dark until the first frame_done.
- value=0x1A2F, digit_en=F, lz_blank=0, defaults. Expected slots:
  - an=1110, seg=0x0E
  - an=1101, seg=0x24
  - an=1011, seg=0x08
  - an=0111, seg=0x79
  - The sequence repeats every frame.
- Leading-zero blanking, lz_blank=1:
  - value=0x0005: only an=1110 is ever active, with seg=0x12.
  - value=0x0000: digit 0 shows seg=0x40.
  - value=0x0300: digits 2..0 are shown and digit 3 is dark.
- Tearing check: change value 0x1111→0x2222 while idx=1. Digits 2 and 3 still show "1" (seg=0x79). "2" (seg=0x24) first appears on digit 0 right after frame_done.
- Scan monitor, checked on every cycle:
  - Never more than one anode active.
  - Exactly one all-inactive cycle at each digit change.
  - dp[2]=1 → dp_out=0 only while an=1011.
- Assert rst for 1 cycle while digit 2 is lit: an=1111 in that same cycle. After release, the next lit digit is digit 0, and frame_done pulses on that tick.
